// File: rtl/ex_result_if.sv
// ex_result_if: handshake bundle between the ALU, the execute result stage and the
// memory/writeback stage.
//   in_*      : ALU -> stage (in_valid_i/in_ready_o handshake, result, rd fields)
//   out_*     : stage -> downstream (out_valid_o/out_ready_i handshake, head entry)
//   fwd_*     : decode-stage bypass view of the head entry (only with EX_FWD_EN)
// Modports: slave = the stage itself, master = its surroundings (ALU + downstream).
// Configuration macro: EX_FWD_EN adds the fwd_* signals.
interface ex_result_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] alu_result_i;
  logic              is_cmp_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_wren_i;

  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] result_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              rd_wren_o;

`ifdef EX_FWD_EN
  logic              fwd_valid_o;
  logic [ADDR_W-1:0] fwd_addr_o;
  logic [DATA_W-1:0] fwd_data_o;

  modport slave (
    input  in_valid_i, alu_result_i, is_cmp_i, rd_addr_i, rd_wren_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, rd_addr_o, rd_wren_o,
    output fwd_valid_o, fwd_addr_o, fwd_data_o
  );

  modport master (
    output in_valid_i, alu_result_i, is_cmp_i, rd_addr_i, rd_wren_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, rd_addr_o, rd_wren_o,
    input  fwd_valid_o, fwd_addr_o, fwd_data_o
  );
`else
  modport slave (
    input  in_valid_i, alu_result_i, is_cmp_i, rd_addr_i, rd_wren_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, rd_addr_o, rd_wren_o
  );

  modport master (
    output in_valid_i, alu_result_i, is_cmp_i, rd_addr_i, rd_wren_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, rd_addr_o, rd_wren_o
  );
`endif
endinterface

// File: rtl/ex_result_stage.sv
// ex_result_stage: execute-stage result register with a 2-entry skid buffer (main + skid).
// Captures the normalised ALU result, destination address and write enable and hands them
// downstream over valid/ready. in_ready_o is a flop, so there is no combinational path from
// out_ready_i back to the ALU.
// Ports:
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous active-high reset
//   flush_i     : synchronous discard of both entries (highest priority)
//   bus         : ex_result_if.slave (input/output handshakes, optional fwd_* port)
//   stall_cnt_o : saturating count of cycles with out_valid_o=1 and out_ready_i=0
// Configuration macro: EX_FWD_EN drives fwd_valid_o/fwd_addr_o/fwd_data_o from the main entry.
module ex_result_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  ex_result_if.slave       bus,
  output logic [15:0]      stall_cnt_o
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_result_q, skid_result_q;
  logic [ADDR_W-1:0] main_addr_q, skid_addr_q;
  logic              main_wren_q, skid_wren_q;
  logic [15:0]       stall_cnt_q;

  logic              out_valid;
  logic              accept, send;
  logic [DATA_W-1:0] cap_result;
  logic              cap_wren;

  always_comb begin
    out_valid = (state_q != StEmpty);
    accept    = bus.in_valid_i & in_ready_q;
    send      = out_valid & bus.out_ready_i;
    // Compare ops only produce bit 0; x0 is never a real write target.
    cap_result = bus.is_cmp_i ? {{(DATA_W-1){1'b0}}, bus.alu_result_i[0]} : bus.alu_result_i;
    cap_wren   = bus.rd_wren_i & (bus.rd_addr_i != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StEmpty;
      in_ready_q    <= 1'b1;
      main_result_q <= '0;
      main_addr_q   <= '0;
      main_wren_q   <= 1'b0;
      skid_result_q <= '0;
      skid_addr_q   <= '0;
      skid_wren_q   <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      if (out_valid && !bus.out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end

      if (flush_i) begin
        state_q       <= StEmpty;
        in_ready_q    <= 1'b1;
        main_result_q <= '0;
        main_addr_q   <= '0;
        main_wren_q   <= 1'b0;
        skid_result_q <= '0;
        skid_addr_q   <= '0;
        skid_wren_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (accept) begin
              main_result_q <= cap_result;
              main_addr_q   <= bus.rd_addr_i;
              main_wren_q   <= cap_wren;
              state_q       <= StOne;
            end
          end
          StOne: begin
            if (accept && send) begin
              main_result_q <= cap_result;
              main_addr_q   <= bus.rd_addr_i;
              main_wren_q   <= cap_wren;
            end else if (accept) begin
              skid_result_q <= cap_result;
              skid_addr_q   <= bus.rd_addr_i;
              skid_wren_q   <= cap_wren;
              state_q       <= StFull;
              in_ready_q    <= 1'b0;
            end else if (send) begin
              state_q <= StEmpty;
            end
          end
          StFull: begin
            // in_ready_q is 0 here, so only a send can change anything.
            if (send) begin
              main_result_q <= skid_result_q;
              main_addr_q   <= skid_addr_q;
              main_wren_q   <= skid_wren_q;
              state_q       <= StOne;
              in_ready_q    <= 1'b1;
            end
          end
          default: begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid;
  assign bus.result_o    = main_result_q;
  assign bus.rd_addr_o   = main_addr_q;
  assign bus.rd_wren_o   = main_wren_q;
  assign stall_cnt_o     = stall_cnt_q;

`ifdef EX_FWD_EN
  assign bus.fwd_valid_o = out_valid & main_wren_q;
  assign bus.fwd_addr_o  = main_addr_q;
  assign bus.fwd_data_o  = main_result_q;
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
// tb_ex_result_stage: directed bench for ex_result_stage. The driver pushes the hand-computed
// expected entry into a scoreboard queue on every accepted input; a separate monitor pops and
// compares on every completed output handshake.
module tb_ex_result_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [37:0] exp_q[$];

  ex_result_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  ex_result_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .bus         (bus),
    .stall_cnt_o (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Offer one entry until accepted (bounded); expected values are supplied by the caller.
  task automatic send_entry(input logic [31:0] d, input logic cmp, input logic [4:0] a,
                            input logic w, input logic [31:0] exp_d, input logic exp_w);
    bit done = 0;
    bus.in_valid_i   = 1'b1;
    bus.alu_result_i = d;
    bus.is_cmp_i     = cmp;
    bus.rd_addr_i    = a;
    bus.rd_wren_i    = w;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        exp_q.push_back({exp_d, a, exp_w});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: entry %h not accepted, expected acceptance", d);
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares each delivered head entry against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got result %h addr %0d, expected no output",
                 bus.result_o, bus.rd_addr_o);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        chk("out_result", 64'(bus.result_o), 64'(e[37:6]));
        chk("out_addr", 64'(bus.rd_addr_o), 64'(e[5:1]));
        chk("out_wren", 64'(bus.rd_wren_o), 64'(e[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid_i   = 1'b0;
    bus.alu_result_i = '0;
    bus.is_cmp_i     = 1'b0;
    bus.rd_addr_i    = '0;
    bus.rd_wren_i    = 1'b0;
    bus.out_ready_i  = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("rst_result", 64'(bus.result_o), 64'd0);
    chk("rst_addr", 64'(bus.rd_addr_o), 64'd0);
    chk("rst_wren", 64'(bus.rd_wren_o), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic accept, one-cycle latency
    send_entry(32'h0000_1234, 1'b0, 5'd5, 1'b1, 32'h0000_1234, 1'b1);
    chk("lat_out_valid", 64'(bus.out_valid_o), 64'd1);
    chk("lat_result", 64'(bus.result_o), 64'h1234);
    idle(2);

    // Normalisation
    send_entry(32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1, 32'h0000_0001, 1'b1);
    send_entry(32'h0000_ABCD, 1'b0, 5'd0, 1'b1, 32'h0000_ABCD, 1'b0);
    send_entry(32'h8000_0000, 1'b1, 5'd9, 1'b0, 32'h0000_0000, 1'b0);
    idle(2);

    // Backpressure: A, B fill the buffer, C held off
    bus.out_ready_i = 1'b0;
    send_entry(32'hAAAA_0001, 1'b0, 5'd1, 1'b1, 32'hAAAA_0001, 1'b1);
    send_entry(32'hBBBB_0002, 1'b0, 5'd2, 1'b1, 32'hBBBB_0002, 1'b1);
    chk("full_in_ready", 64'(bus.in_ready_o), 64'd0);
    chk("full_head", 64'(bus.result_o), 64'hAAAA_0001);
    bus.in_valid_i   = 1'b1;
    bus.alu_result_i = 32'hCCCC_0003;
    bus.is_cmp_i     = 1'b0;
    bus.rd_addr_i    = 5'd3;
    bus.rd_wren_i    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("c_held_off", 64'(bus.in_ready_o), 64'd0);
      chk("stall_head_stable", 64'(bus.result_o), 64'hAAAA_0001);
      @(posedge clk);
      #1;
    end
    // Stalled edges: B accept edge + 3 hold edges
    chk("stall_cnt_4", 64'(stall_cnt), 64'd4);
    bus.out_ready_i = 1'b1;
    send_entry(32'hCCCC_0003, 1'b0, 5'd3, 1'b1, 32'hCCCC_0003, 1'b1);
    idle(4);
    chk("stall_cnt_hold", 64'(stall_cnt), 64'd4);

    // Flush in FULL with a simultaneous offer
    bus.out_ready_i = 1'b0;
    send_entry(32'hDDDD_0004, 1'b0, 5'd4, 1'b1, 32'hDDDD_0004, 1'b1);
    send_entry(32'hEEEE_0005, 1'b0, 5'd5, 1'b1, 32'hEEEE_0005, 1'b1);
    flush = 1'b1;
    bus.in_valid_i   = 1'b1;
    bus.alu_result_i = 32'hF1F1_F1F1;
    bus.rd_addr_i    = 5'd6;
    @(posedge clk);
    exp_q.delete();
    #1;
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("flush_full_valid", 64'(bus.out_valid_o), 64'd0);
    chk("flush_full_ready", 64'(bus.in_ready_o), 64'd1);

    // Flush in ONE: the offer is accepted but dropped
    send_entry(32'h6666_0006, 1'b0, 5'd6, 1'b1, 32'h6666_0006, 1'b1);
    flush = 1'b1;
    bus.in_valid_i   = 1'b1;
    bus.alu_result_i = 32'h7777_0007;
    bus.rd_addr_i    = 5'd7;
    @(posedge clk);
    exp_q.delete();
    #1;
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("flush_one_valid", 64'(bus.out_valid_o), 64'd0);
    chk("flush_one_ready", 64'(bus.in_ready_o), 64'd1);
    bus.out_ready_i = 1'b1;
    idle(5);
    chk("stall_cnt_7", 64'(stall_cnt), 64'd7);

    // Async reset mid-cycle in FULL
    bus.out_ready_i = 1'b0;
    send_entry(32'h1111_0008, 1'b0, 5'd8, 1'b1, 32'h1111_0008, 1'b1);
    send_entry(32'h2222_0009, 1'b0, 5'd9, 1'b1, 32'h2222_0009, 1'b1);
    chk("stall_cnt_8", 64'(stall_cnt), 64'd8);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("arst_result", 64'(bus.result_o), 64'd0);
    chk("arst_addr", 64'(bus.rd_addr_o), 64'd0);
    chk("arst_wren", 64'(bus.rd_wren_o), 64'd0);
    chk("arst_stall", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;

    // Full throughput after reset
    send_entry(32'h0000_0010, 1'b0, 5'd10, 1'b1, 32'h0000_0010, 1'b1);
    chk("tput_ready", 64'(bus.in_ready_o), 64'd1);
    send_entry(32'h0000_0011, 1'b0, 5'd11, 1'b1, 32'h0000_0011, 1'b1);
    chk("tput_ready2", 64'(bus.in_ready_o), 64'd1);
    send_entry(32'h0000_0012, 1'b1, 5'd12, 1'b1, 32'h0000_0000, 1'b1);
    idle(3);
    chk("tput_no_stall", 64'(stall_cnt), 64'd0);

`ifdef EX_FWD_EN
    bus.out_ready_i = 1'b0;
    send_entry(32'hDEAD_BEEF, 1'b0, 5'd7, 1'b1, 32'hDEAD_BEEF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fwd_valid", 64'(bus.fwd_valid_o), 64'd1);
      chk("fwd_addr", 64'(bus.fwd_addr_o), 64'd7);
      chk("fwd_data", 64'(bus.fwd_data_o), 64'hDEAD_BEEF);
      @(posedge clk);
      #1;
    end
    bus.out_ready_i = 1'b1;
    idle(3);
    chk("fwd_idle_valid", 64'(bus.fwd_valid_o), 64'd0);
`endif

    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
